// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams and uart_tx handshake for the shared transmitter.
//   req_valid/req_data/req_last : per-requester byte offer (data slice i at [i*PAYLOAD_BITS +: PAYLOAD_BITS])
//   req_ready                   : one-hot acceptance of the grantee's byte
//   tx_en/tx_data/tx_busy       : send strobe, byte and busy flag of uart_tx
//   grant_active/grant_id       : message in progress and its owner
//   msg_done                    : pulse once the final byte of a message has left the UART
//   slave  : the arbiter's view; master : the producers/uart_tx view
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ      = 3,
    parameter int PAYLOAD_BITS = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]              req_last;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            tx_en;
    logic [PAYLOAD_BITS-1:0]         tx_data;
    logic                            tx_busy;
    logic                            grant_active;
    logic [GW-1:0]                   grant_id;
    logic                            msg_done;
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_en, tx_data, grant_active, grant_id, msg_done
    );
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_en, tx_data, grant_active, grant_id, msg_done
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one uart_tx among NUM_REQ byte streams.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : uart_tx_arbiter_if.slave (requester offers/ready, uart_tx en/data/busy, grant status, msg_done)
//   UART_ARB_ID_PREFIX_EN : when defined, each message is preceded by header byte ID_BASE+grant_id
module uart_tx_arbiter #(
    parameter int                      NUM_REQ      = 3,
    parameter int                      PAYLOAD_BITS = 8,
    parameter logic [PAYLOAD_BITS-1:0] ID_BASE      = 8'h30
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
`ifdef UART_ARB_ID_PREFIX_EN
        , HDR
`endif
    } state_t;
    state_t                  state, state_nx;
    logic [GW-1:0]           grant_id, ptr, winner, cand;
    logic                    grant_active, last_flag, msg_done;
    logic                    any_valid, fire, hdr_fire, done_nx;
    logic [PAYLOAD_BITS-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Scan from farthest to nearest so the valid requester closest after ptr wins.
    always_comb begin
        winner    = ptr;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GW'((int'(ptr) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign fire = state == ISSUE && bus.req_valid[grant_id] && !bus.tx_busy;
`ifdef UART_ARB_ID_PREFIX_EN
    assign hdr_fire = state == HDR && !bus.tx_busy;
`else
    assign hdr_fire = 1'b0;
`endif
    assign done_nx = state == WAIT_LO && !bus.tx_busy && last_flag;

    assign bus.tx_en        = fire || hdr_fire;
    assign bus.tx_data      = fire ? slice[grant_id] : hdr_fire ? ID_BASE + PAYLOAD_BITS'(grant_id) : '0;
    assign bus.req_ready    = fire ? NUM_REQ'(1) << grant_id : '0;
    assign bus.grant_active = grant_active;
    assign bus.grant_id     = grant_id;
    assign bus.msg_done     = msg_done;

    always_comb begin
        state_nx = state;
        case (state)
`ifdef UART_ARB_ID_PREFIX_EN
            IDLE:    state_nx = any_valid ? HDR : IDLE;
            HDR:     state_nx = hdr_fire ? WAIT_HI : HDR;
`else
            IDLE:    state_nx = any_valid ? ISSUE : IDLE;
`endif
            ISSUE:   state_nx = fire ? WAIT_HI : ISSUE;
            WAIT_HI: state_nx = bus.tx_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: state_nx = bus.tx_busy ? WAIT_LO : last_flag ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant_id     <= '0;
            grant_active <= 1'b0;
            ptr          <= GW'(NUM_REQ - 1);
            last_flag    <= 1'b0;
            msg_done     <= 1'b0;
        end else begin
            state    <= state_nx;
            msg_done <= done_nx;
            if (state == IDLE && any_valid) begin
                grant_id     <= winner;
                ptr          <= winner;
                grant_active <= 1'b1;
            end else if (done_nx) begin
                grant_active <= 1'b0;
            end
            if (fire) last_flag <= bus.req_last[grant_id];
            else if (hdr_fire) last_flag <= 1'b0;
        end
    end
endmodule
